// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared types and constants for the BCD timer
package bcd_timer_pkg;

  // Width of one BCD decade.
  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_SAT   = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_timer_if.sv
// rtl/bcd_timer_if.sv - control and status bundle of the BCD timer
interface bcd_timer_if #(
  parameter int NDIG = 4
);
  import bcd_timer_pkg::*;

  logic                    time_clr;
  logic                    time_en;
  logic                    time_hold;
  logic [BCD_W*NDIG-1:0]   digits;
  logic                    time_late;
  logic                    time_ovf;
  logic                    running;

  modport master (
    output time_clr, time_en, time_hold,
    input  digits, time_late, time_ovf, running
  );

  modport slave (
    input  time_clr, time_en, time_hold,
    output digits, time_late, time_ovf, running
  );

endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade with carry chain and all-nine detect
module bcd_digit
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en_in,
  input  logic             freeze,
  output logic             carry_out,
  output logic             nine,
  output logic [BCD_W-1:0] q_next
);

  logic [BCD_W-1:0] q;

  assign nine      = (q == BCD_W'(9));
  // Carry ripples combinationally so every decade settles within one edge.
  assign carry_out = en_in & nine;

  // Next decade value; freeze blocks the wrap when the whole count is at all nines.
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (en_in && !freeze) begin
      q_next = nine ? '0 : q + BCD_W'(1);
    end
  end

  // Decade register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_next;
  end

endmodule

// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - prescaled BCD up-counter with lap hold, late and overflow flags
module bcd_timer
  import bcd_timer_pkg::*;
#(
  parameter int NDIG       = 4,
  parameter int TICK_DIV   = 1,
  parameter int LATE_TICKS = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  bcd_timer_if.slave  tif
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LATE_W  = $clog2(LATE_TICKS + 1);

  state_t                state_q, state_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [LATE_W-1:0]     late_cnt_q, late_cnt_d;
  logic [BCD_W*NDIG-1:0] count_next;
  logic [BCD_W*NDIG-1:0] digits_q;
  logic [NDIG-1:0]       carry;
  logic [NDIG-1:0]       nine_vec;
  logic                  tick;
  logic                  sat_evt;
  logic                  late_q;
  logic                  ovf_q;

  // Prescaler advances only while counting; pausing keeps the partial period.
  always_comb begin
    tick    = 1'b0;
    presc_d = presc_q;
    if (tif.time_clr) begin
      presc_d = '0;
    end else if (state_q == ST_RUN && tif.time_en) begin
      if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NDIG; k++) begin : g_dig
      bcd_digit u_digit (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tif.time_clr),
        .en_in     ((k == 0) ? tick : carry[(k == 0) ? 0 : k - 1]),
        .freeze    (&nine_vec),
        .carry_out (carry[k]),
        .nine      (nine_vec[k]),
        .q_next    (count_next[BCD_W*k +: BCD_W])
      );
    end
  endgenerate

  // A carry out of the top decade means a tick arrived at all nines.
  assign sat_evt = carry[NDIG-1];

  // Late tick counter saturates at the threshold.
  always_comb begin
    late_cnt_d = late_cnt_q;
    if (tif.time_clr) begin
      late_cnt_d = '0;
    end else if (tick && late_cnt_q != LATE_W'(LATE_TICKS)) begin
      late_cnt_d = late_cnt_q + LATE_W'(1);
    end
  end

  // State, prescaler, late counter, sticky flags and lap-hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      late_cnt_q <= '0;
      late_q     <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      late_cnt_q <= late_cnt_d;
      if (tif.time_clr) begin
        late_q   <= 1'b0;
        ovf_q    <= 1'b0;
        digits_q <= '0;
      end else begin
        if (late_cnt_d == LATE_W'(LATE_TICKS)) late_q <= 1'b1;
        if (sat_evt)                            ovf_q  <= 1'b1;
        if (!tif.time_hold)                     digits_q <= count_next;
      end
    end
  end

  // Next-state logic; clear wins over everything.
  always_comb begin
    state_d = state_q;
    if (tif.time_clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (tif.time_en) state_d = ST_RUN;
        ST_RUN: begin
          if (sat_evt)           state_d = ST_SAT;
          else if (!tif.time_en) state_d = ST_PAUSE;
        end
        ST_PAUSE: if (tif.time_en) state_d = ST_RUN;
        ST_SAT:   state_d = ST_SAT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    tif.running   = (state_q == ST_RUN);
    tif.digits    = digits_q;
    tif.time_late = late_q;
    tif.time_ovf  = ovf_q;
  end

endmodule

// File: tb/tb_bcd_timer.sv
// tb/tb_bcd_timer.sv - directed self-checking bench for bcd_timer
module tb_bcd_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  bcd_timer_if #(.NDIG(4)) if_a ();
  bcd_timer_if #(.NDIG(4)) if_b ();
  bcd_timer_if #(.NDIG(2)) if_c ();

  bcd_timer #(.NDIG(4), .TICK_DIV(1), .LATE_TICKS(5000)) u_a (
    .clk (clk), .rst_n (rst_n), .tif (if_a)
  );
  bcd_timer #(.NDIG(4), .TICK_DIV(3), .LATE_TICKS(5000)) u_b (
    .clk (clk), .rst_n (rst_n), .tif (if_b)
  );
  bcd_timer #(.NDIG(2), .TICK_DIV(1), .LATE_TICKS(50)) u_c (
    .clk (clk), .rst_n (rst_n), .tif (if_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    if_a.time_clr = 1'b0; if_a.time_en = 1'b0; if_a.time_hold = 1'b0;
    if_b.time_clr = 1'b0; if_b.time_en = 1'b0; if_b.time_hold = 1'b0;
    if_c.time_clr = 1'b0; if_c.time_en = 1'b0; if_c.time_hold = 1'b0;

    step(2);
    check_eq("rst_digits",  {16'h0, if_a.digits}, 32'h0);
    check_eq("rst_running", {31'h0, if_a.running}, 32'h0);
    check_eq("rst_late",    {31'h0, if_a.time_late}, 32'h0);
    check_eq("rst_ovf",     {31'h0, if_a.time_ovf}, 32'h0);
    rst_n = 1'b1;
    step(1);

    // Count 1234: first enabled edge enters RUN, the next 1234 edges tick.
    if_a.time_clr = 1'b1; step(1);
    if_a.time_clr = 1'b0; if_a.time_en = 1'b1; step(1235);
    check_eq("cnt1234_digits",  {16'h0, if_a.digits}, 32'h1234);
    check_eq("cnt1234_running", {31'h0, if_a.running}, 32'h1);
    check_eq("cnt1234_late",    {31'h0, if_a.time_late}, 32'h0);

    // Lap hold: freeze at 0040 for 30 ticks, release with en low shows 0070.
    if_a.time_clr = 1'b1; step(1);
    if_a.time_clr = 1'b0; step(41);
    check_eq("hold_pre", {16'h0, if_a.digits}, 32'h0040);
    if_a.time_hold = 1'b1; step(30);
    check_eq("hold_frozen", {16'h0, if_a.digits}, 32'h0040);
    if_a.time_hold = 1'b0; if_a.time_en = 1'b0; step(1);
    check_eq("hold_release", {16'h0, if_a.digits}, 32'h0070);
    check_eq("hold_paused",  {31'h0, if_a.running}, 32'h0);

    // Clear with en and hold at 0777, then async reset mid-count.
    if_a.time_clr = 1'b1; step(1);
    if_a.time_clr = 1'b0; if_a.time_en = 1'b1; step(778);
    check_eq("c777_digits", {16'h0, if_a.digits}, 32'h0777);
    if_a.time_hold = 1'b1; step(5);
    check_eq("c777_held", {16'h0, if_a.digits}, 32'h0777);
    if_a.time_clr = 1'b1; step(1);
    check_eq("clr_digits",  {16'h0, if_a.digits}, 32'h0);
    check_eq("clr_running", {31'h0, if_a.running}, 32'h0);
    check_eq("clr_ovf",     {31'h0, if_a.time_ovf}, 32'h0);
    check_eq("clr_late",    {31'h0, if_a.time_late}, 32'h0);
    if_a.time_clr = 1'b0; if_a.time_hold = 1'b0; step(1);
    check_eq("clr_then_run", {31'h0, if_a.running}, 32'h1);
    step(10);
    check_eq("after_clr_cnt", {16'h0, if_a.digits}, 32'h0010);
    if_a.time_hold = 1'b1; step(3);
    #3 rst_n = 1'b0;
    #1;
    check_eq("arst_digits",  {16'h0, if_a.digits}, 32'h0);
    check_eq("arst_running", {31'h0, if_a.running}, 32'h0);
    step(1);
    if_a.time_en = 1'b0; if_a.time_hold = 1'b0;
    rst_n = 1'b1;
    step(1);
    check_eq("arst_idle_digits", {16'h0, if_a.digits}, 32'h0);

    // Prescaler of 3: 5 enabled, 10 paused, then resume keeps the partial period.
    if_b.time_clr = 1'b1; step(1);
    if_b.time_clr = 1'b0; if_b.time_en = 1'b1; step(5);
    check_eq("div3_first",   {16'h0, if_b.digits}, 32'h0001);
    check_eq("div3_running", {31'h0, if_b.running}, 32'h1);
    if_b.time_en = 1'b0; step(10);
    check_eq("div3_pause_digits", {16'h0, if_b.digits}, 32'h0001);
    check_eq("div3_pause_run",    {31'h0, if_b.running}, 32'h0);
    if_b.time_en = 1'b1; step(2);
    check_eq("div3_resume_digits", {16'h0, if_b.digits}, 32'h0001);
    check_eq("div3_resume_run",    {31'h0, if_b.running}, 32'h1);
    step(1);
    check_eq("div3_second", {16'h0, if_b.digits}, 32'h0002);

    // Two decades, late at 50, saturation at 99.
    if_c.time_clr = 1'b1; step(1);
    if_c.time_clr = 1'b0; if_c.time_en = 1'b1; step(50);
    check_eq("late_before", {31'h0, if_c.time_late}, 32'h0);
    check_eq("c49_digits",  {24'h0, if_c.digits}, 32'h49);
    step(1);
    check_eq("late_at50",  {31'h0, if_c.time_late}, 32'h1);
    check_eq("c50_digits", {24'h0, if_c.digits}, 32'h50);
    step(49);
    check_eq("c99_digits", {24'h0, if_c.digits}, 32'h99);
    check_eq("c99_ovf",    {31'h0, if_c.time_ovf}, 32'h0);
    step(1);
    check_eq("sat_digits",  {24'h0, if_c.digits}, 32'h99);
    check_eq("sat_ovf",     {31'h0, if_c.time_ovf}, 32'h1);
    check_eq("sat_running", {31'h0, if_c.running}, 32'h0);
    check_eq("sat_late",    {31'h0, if_c.time_late}, 32'h1);
    if_c.time_en = 1'b0; step(3);
    if_c.time_en = 1'b1; step(3);
    check_eq("sat_toggle_digits",  {24'h0, if_c.digits}, 32'h99);
    check_eq("sat_toggle_running", {31'h0, if_c.running}, 32'h0);
    check_eq("sat_toggle_ovf",     {31'h0, if_c.time_ovf}, 32'h1);
    if_c.time_clr = 1'b1; step(1);
    check_eq("sat_clr_digits", {24'h0, if_c.digits}, 32'h0);
    check_eq("sat_clr_ovf",    {31'h0, if_c.time_ovf}, 32'h0);
    check_eq("sat_clr_late",   {31'h0, if_c.time_late}, 32'h0);
    if_c.time_clr = 1'b0; step(1);
    check_eq("sat_clr_rerun", {31'h0, if_c.running}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
